// File: rtl/bram_reader_2out_if.sv
// Bus bundle for bram_reader_2out: the frame BRAM read port plus the two
// split output streams (a = upper field, b = lower field).
//   rd_bram_index/rd_address/rd_ena : read request towards the BRAM
//   rd_data                         : BRAM read data {a, b}
//   a_data/a_valid/a_ready          : stream a handshake
//   b_data/b_valid/b_ready          : stream b handshake
// master = the reader, slave = BRAM + downstream consumers.
interface bram_reader_2out_if #(
  parameter int unsigned addr_bits = 15,
  parameter int unsigned a_width   = 13,
  parameter int unsigned b_width   = 8
);
  logic                         rd_bram_index;
  logic [addr_bits-1:0]         rd_address;
  logic                         rd_ena;
  logic [a_width+b_width-1:0]   rd_data;
  logic [a_width-1:0]           a_data;
  logic                         a_valid;
  logic                         a_ready;
  logic [b_width-1:0]           b_data;
  logic                         b_valid;
  logic                         b_ready;

  modport master (
    output rd_bram_index, rd_address, rd_ena,
    input  rd_data,
    output a_data, a_valid,
    input  a_ready,
    output b_data, b_valid,
    input  b_ready
  );

  modport slave (
    input  rd_bram_index, rd_address, rd_ena,
    output rd_data,
    input  a_data, a_valid,
    output a_ready,
    input  b_data, b_valid,
    output b_ready
  );
endinterface

// File: rtl/bram_reader_2out.sv
// Frame reader: on start, reads one frame of packed {a, b} words from the
// selected BRAM bank and splits each word into two independently handshaked
// streams. A credit-controlled FIFO absorbs the fixed BRAM read latency.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   start           : begin a frame (honoured only while idle)
//   bram_index_in   : bank select, latched on accepted start
//   idle            : no frame in progress
//   done            : one-cycle pulse after the final word left both streams
//   bus (master)    : BRAM read port and a/b output streams
module bram_reader_2out #(
  parameter int unsigned width      = 120,
  parameter int unsigned height     = 240,
  parameter int unsigned a_width    = 13,
  parameter int unsigned b_width    = 8,
  parameter int unsigned rd_latency = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               bram_index_in,
  output logic               idle,
  output logic               done,
  bram_reader_2out_if.master bus
);
  localparam int unsigned frame_size = width * height;
  localparam int unsigned addr_bits  = $clog2(frame_size);
  localparam int unsigned fifo_depth = rd_latency + 2;
  localparam int unsigned word_width = a_width + b_width;
  localparam int unsigned ptr_bits   = $clog2(fifo_depth);
  localparam int unsigned cnt_bits   = $clog2(fifo_depth + 2);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN} state_t;

  state_t                 state;
  logic                   rd_ena_q;
  logic [addr_bits-1:0]   rd_addr_q;
  logic                   bank_q;
  logic [rd_latency-1:0]  inflight;
  logic [word_width-1:0]  fifo_mem [fifo_depth];
  logic [ptr_bits-1:0]    wr_ptr;
  logic [ptr_bits-1:0]    rd_ptr;
  logic [cnt_bits-1:0]    fifo_count;
  logic                   a_taken;
  logic                   b_taken;

  logic [word_width-1:0]  head;
  logic                   a_valid_c, b_valid_c;
  logic                   a_fire, b_fire, pop, capture;
  logic [rd_latency-1:0]  inflight_next;
  logic [cnt_bits-1:0]    count_next;
  logic [cnt_bits-1:0]    outstanding_next;
  logic                   credit;
  logic                   last_issue;
  logic                   last_pop;

  // Stream handshake and FIFO head decode
  assign head      = fifo_mem[rd_ptr];
  assign a_valid_c = (fifo_count != '0) && !a_taken;
  assign b_valid_c = (fifo_count != '0) && !b_taken;
  assign a_fire    = a_valid_c && bus.a_ready;
  assign b_fire    = b_valid_c && bus.b_ready;
  assign pop       = (fifo_count != '0) && (a_taken || a_fire) && (b_taken || b_fire);
  assign capture   = inflight[rd_latency-1];

  // The read presented this cycle enters the tracker at the coming edge
  assign inflight_next = rd_latency'({inflight, rd_ena_q});
  assign count_next    = fifo_count + cnt_bits'(capture) - cnt_bits'(pop);

  // Reads still owed to the FIFO after the coming edge
  always_comb begin
    outstanding_next = '0;
    for (int unsigned i = 0; i < rd_latency; i++)
      outstanding_next = outstanding_next + cnt_bits'(inflight_next[i]);
  end

  // A new read may be presented only if every owed word still fits
  assign credit     = (count_next + outstanding_next + cnt_bits'(1)) <= cnt_bits'(fifo_depth);
  assign last_issue = rd_ena_q && (rd_addr_q == addr_bits'(frame_size - 1));
  assign last_pop   = pop && (fifo_count == cnt_bits'(1)) && (inflight == '0);

  // Control FSM, read issue, return capture and stream bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idle       <= 1'b1;
      done       <= 1'b0;
      rd_ena_q   <= 1'b0;
      rd_addr_q  <= '0;
      bank_q     <= 1'b0;
      inflight   <= '0;
      fifo_mem   <= '{default: '0};
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      a_taken    <= 1'b0;
      b_taken    <= 1'b0;
    end else begin
      done       <= 1'b0;
      rd_ena_q   <= 1'b0;
      inflight   <= inflight_next;
      fifo_count <= count_next;

      if (capture) begin
        fifo_mem[wr_ptr] <= bus.rd_data;
        wr_ptr <= (wr_ptr == ptr_bits'(fifo_depth - 1)) ? '0 : wr_ptr + ptr_bits'(1);
      end

      if (pop) begin
        rd_ptr  <= (rd_ptr == ptr_bits'(fifo_depth - 1)) ? '0 : rd_ptr + ptr_bits'(1);
        a_taken <= 1'b0;
        b_taken <= 1'b0;
      end else begin
        a_taken <= a_taken || a_fire;
        b_taken <= b_taken || b_fire;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_ISSUE;
            idle      <= 1'b0;
            bank_q    <= bram_index_in;
            rd_addr_q <= '0;
            rd_ena_q  <= credit;
          end
        end
        ST_ISSUE: begin
          if (last_issue) begin
            state <= ST_DRAIN;
          end else begin
            if (rd_ena_q) rd_addr_q <= rd_addr_q + addr_bits'(1);
            rd_ena_q <= credit;
          end
        end
        ST_DRAIN: begin
          if (last_pop) begin
            state <= ST_IDLE;
            idle  <= 1'b1;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_bram_index = bank_q;
  assign bus.rd_address    = rd_addr_q;
  assign bus.rd_ena        = rd_ena_q;
  assign bus.a_data        = head[word_width-1:b_width];
  assign bus.b_data        = head[b_width-1:0];
  assign bus.a_valid       = a_valid_c;
  assign bus.b_valid       = b_valid_c;
endmodule

// File: tb/tb_bram_reader_2out.sv
// Bench for bram_reader_2out on a 4x2 frame with a 2-cycle BRAM model that
// returns {a = 0x100 + addr, b = 0xA0 + addr}.
module tb_bram_reader_2out;
  localparam int unsigned AW = 13;
  localparam int unsigned BW = 8;
  localparam int unsigned FRAME = 8;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic bram_index_in;
  logic idle;
  logic done;
  logic a_ready;
  logic b_ready;

  bram_reader_2out_if #(.addr_bits(3), .a_width(AW), .b_width(BW)) bus ();

  bram_reader_2out #(
    .width(4), .height(2), .a_width(AW), .b_width(BW), .rd_latency(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bram_index_in(bram_index_in),
    .idle(idle),
    .done(done),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // BRAM model: address sampled at an edge, data valid two edges later
  logic [AW+BW-1:0] p1, p2;
  always_ff @(posedge clk) begin
    if (bus.rd_ena) p1 <= {13'h100 + 13'(bus.rd_address), 8'hA0 + 8'(bus.rd_address)};
    p2 <= p1;
  end
  assign bus.rd_data = p2;
  assign bus.a_ready = a_ready;
  assign bus.b_ready = b_ready;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_idle"},   32'(idle), 32'(1));
    chk({tag, "_done"},   32'(done), 32'(0));
    chk({tag, "_rd_ena"}, 32'(bus.rd_ena), 32'(0));
    chk({tag, "_addr"},   32'(bus.rd_address), 32'(0));
    chk({tag, "_bank"},   32'(bus.rd_bram_index), 32'(0));
    chk({tag, "_avalid"}, 32'(bus.a_valid), 32'(0));
    chk({tag, "_bvalid"}, 32'(bus.b_valid), 32'(0));
    chk({tag, "_adata"},  32'(bus.a_data), 32'(0));
    chk({tag, "_bdata"},  32'(bus.b_data), 32'(0));
  endtask

  typedef struct {
    logic start;
    logic bank;
    logic e_rd_ena;
    int   e_addr;
    logic e_av;
    int   e_a;
    logic e_bv;
    int   e_b;
    logic e_idle;
    logic e_done;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic bk, input logic en, input int addr,
                              input logic av, input int a, input logic bv, input int b,
                              input logic idl, input logic dn);
    vec_t v;
    v.start = st; v.bank = bk; v.e_rd_ena = en; v.e_addr = addr;
    v.e_av = av; v.e_a = a; v.e_bv = bv; v.e_b = b; v.e_idle = idl; v.e_done = dn;
    return v;
  endfunction

  // One frame with a monitor: in-order data, stability under backpressure,
  // occupancy bound, address sequence, bank, done timing. An ignored start
  // (with the other bank) is pulsed at cycle 5.
  task automatic frame(input logic bank, input int stall, input bit rnd);
    int   a_idx, b_idx, issued, popped;
    bit   fin;
    logic ar, br, prev_av, prev_bv, prev_ar, prev_br;
    logic [AW-1:0] prev_a;
    logic [BW-1:0] prev_b;
    a_idx = 0; b_idx = 0; issued = 0; fin = 1'b0;
    prev_av = 1'b0; prev_bv = 1'b0; prev_ar = 1'b0; prev_br = 1'b0;
    prev_a = '0; prev_b = '0;
    start = 1'b1;
    bram_index_in = bank;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      start = (cyc == 5);
      bram_index_in = (cyc == 5) ? ~bank : bank;
      if (cyc < stall) begin
        ar = 1'b1; br = 1'b0;
      end else if (rnd) begin
        ar = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1));
      end else begin
        ar = 1'b1; br = 1'b1;
      end
      a_ready = ar;
      b_ready = br;
      popped = (a_idx < b_idx) ? a_idx : b_idx;
      if (bus.rd_ena) begin
        issued++;
        chk("rd_address", 32'(bus.rd_address), 32'(issued - 1));
      end
      chk("occupancy", 32'((issued - popped) <= 4), 32'(1));
      chk("bank", 32'(bus.rd_bram_index), 32'(bank));
      if (prev_av && !prev_ar) begin
        chk("a_hold", 32'(bus.a_valid), 32'(1));
        chk("a_stable", 32'(bus.a_data), 32'(prev_a));
      end
      if (prev_bv && !prev_br) begin
        chk("b_hold", 32'(bus.b_valid), 32'(1));
        chk("b_stable", 32'(bus.b_data), 32'(prev_b));
      end
      if (cyc >= 4 && cyc < stall) begin
        chk("stall_rd_ena", 32'(bus.rd_ena), 32'(0));
        chk("stall_avalid", 32'(bus.a_valid), 32'(0));
        chk("stall_bvalid", 32'(bus.b_valid), 32'(1));
        chk("stall_bdata", 32'(bus.b_data), 32'(8'hA0));
      end
      if (cyc == stall - 1) chk("stall_issued", 32'(issued), 32'(4));
      if (bus.a_valid && ar) begin
        chk("a_data", 32'(bus.a_data), 32'(13'h100 + 13'(a_idx)));
        a_idx++;
      end
      if (bus.b_valid && br) begin
        chk("b_data", 32'(bus.b_data), 32'(8'hA0 + 8'(b_idx)));
        b_idx++;
      end
      prev_av = bus.a_valid; prev_bv = bus.b_valid;
      prev_ar = ar; prev_br = br;
      prev_a = bus.a_data; prev_b = bus.b_data;
      if (done) begin
        fin = 1'b1;
        chk("done_a_count", 32'(a_idx), 32'(FRAME));
        chk("done_b_count", 32'(b_idx), 32'(FRAME));
        chk("done_issued", 32'(issued), 32'(FRAME));
        chk("done_idle", 32'(idle), 32'(1));
      end else begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    chk("done_seen", 32'(fin), 32'(1));
  endtask

  vec_t vec [13];

  initial begin
    reset = 1'b1;
    start = 1'b0;
    bram_index_in = 1'b0;
    a_ready = 1'b1;
    b_ready = 1'b1;
    #2;
    check_reset_vals("rst");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Bank 1 frame, both readies high; start at row 4 must be ignored
    vec[0]  = mk(1, 1, 1, 0, 0, 0,      0, 0,     0, 0);
    vec[1]  = mk(0, 0, 1, 1, 0, 0,      0, 0,     0, 0);
    vec[2]  = mk(0, 0, 1, 2, 0, 0,      0, 0,     0, 0);
    vec[3]  = mk(0, 0, 1, 3, 1, 'h100, 1, 'hA0, 0, 0);
    vec[4]  = mk(1, 0, 1, 4, 1, 'h101, 1, 'hA1, 0, 0);
    vec[5]  = mk(0, 0, 1, 5, 1, 'h102, 1, 'hA2, 0, 0);
    vec[6]  = mk(0, 0, 1, 6, 1, 'h103, 1, 'hA3, 0, 0);
    vec[7]  = mk(0, 0, 1, 7, 1, 'h104, 1, 'hA4, 0, 0);
    vec[8]  = mk(0, 0, 0, 0, 1, 'h105, 1, 'hA5, 0, 0);
    vec[9]  = mk(0, 0, 0, 0, 1, 'h106, 1, 'hA6, 0, 0);
    vec[10] = mk(0, 0, 0, 0, 1, 'h107, 1, 'hA7, 0, 0);
    vec[11] = mk(0, 0, 0, 0, 0, 0,      0, 0,     1, 1);
    vec[12] = mk(0, 0, 0, 0, 0, 0,      0, 0,     1, 0);

    for (int i = 0; i < 13; i++) begin
      start = vec[i].start;
      bram_index_in = vec[i].bank;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_rd_ena", i), 32'(bus.rd_ena), 32'(vec[i].e_rd_ena));
      if (vec[i].e_rd_ena)
        chk($sformatf("tbl%0d_addr", i), 32'(bus.rd_address), 32'(vec[i].e_addr));
      chk($sformatf("tbl%0d_bank", i), 32'(bus.rd_bram_index), 32'(1));
      chk($sformatf("tbl%0d_avalid", i), 32'(bus.a_valid), 32'(vec[i].e_av));
      chk($sformatf("tbl%0d_bvalid", i), 32'(bus.b_valid), 32'(vec[i].e_bv));
      if (vec[i].e_av) chk($sformatf("tbl%0d_adata", i), 32'(bus.a_data), 32'(vec[i].e_a));
      if (vec[i].e_bv) chk($sformatf("tbl%0d_bdata", i), 32'(bus.b_data), 32'(vec[i].e_b));
      chk($sformatf("tbl%0d_idle", i), 32'(idle), 32'(vec[i].e_idle));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(vec[i].e_done));
    end
    start = 1'b0;

    // Back-to-back frame, then stream b stalled so credit runs out
    frame(1'b1, 0, 1'b0);
    frame(1'b0, 12, 1'b0);

    // Random independent readies; each frame starts in the done cycle
    for (int f = 0; f < 20; f++) frame(1'($urandom_range(0, 1)), 0, 1'b1);

    // Reset while word 3 is at the head and reads are in flight
    @(posedge clk); #1;
    a_ready = 1'b1;
    b_ready = 1'b1;
    start = 1'b1;
    bram_index_in = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset_avalid", 32'(bus.a_valid), 32'(1));
    chk("pre_reset_adata", 32'(bus.a_data), 32'(13'h103));
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("post_reset_done", 32'(done), 32'(0));
      chk("post_reset_avalid", 32'(bus.a_valid), 32'(0));
      chk("post_reset_idle", 32'(idle), 32'(1));
    end
    frame(1'b0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bram_reader_2out.md
# bram_reader_2out

Downstream counterpart of the dual-stream frame BRAM writer. On `start` it reads one complete frame of packed `{a, b}` words from the selected BRAM bank, covering the BRAM's fixed read latency with a small credit-controlled FIFO. It splits each word into two independently handshaked output streams, so the disparity and pixel consumers of the filtering path can each apply backpressure. It sits between the frame BRAM read port and the disparity filtering / output stages.

## Interface
- `width`, 120, frame width in pixels
- `height`, 240, frame height in lines
- `frame_size`, `width*height`, words per frame
- `addr_bits`, `$clog2(frame_size)`, BRAM address width
- `a_width`, 13, upper field width (disparity/cost)
- `b_width`, 8, lower field width (pixel)
- `rd_latency`, 2, BRAM clocks from address sample to `rd_data` valid; must be ≥1
- `fifo_depth`, `rd_latency+2`, output buffer entries
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  begin frame read; honoured only when `idle`
- `bram_index_in`  in  1  bank to read, latched on accepted `start`
- `idle`  out  1  high when no frame is in progress
- `done`  out  1  one-cycle pulse when the final word is consumed on both streams
- `rd_bram_index`  out  1  latched bank select
- `rd_address`  out  `addr_bits`  BRAM read address
- `rd_ena`  out  1  read strobe
- `rd_data`  in  `a_width+b_width`  BRAM read data, `{a, b}`
- `a_data`  out  `a_width`  `rd_data[a_width+b_width-1:b_width]` of head word
- `a_valid`  out  1  head word not yet taken on stream a
- `a_ready`  in  1  stream a consumer ready
- `b_data`  out  `b_width`  `rd_data[b_width-1:0]` of head word
- `b_valid`  out  1  head word not yet taken on stream b
- `b_ready`  in  1  stream b consumer ready

## Operation
- Reset values: `idle`=1, `done`=0, `rd_ena`=0, `rd_address`=0, `rd_bram_index`=0, `a_valid`=`b_valid`=0, `a_data`=`b_data`=0. FIFO, in-flight tracker and taken flags are cleared.
- FSM states:
  - ST_IDLE: on `start`, latch `bram_index_in` and go to ST_ISSUE with next address 0. `start` in any other state is ignored.
  - ST_ISSUE: assert `rd_ena` with the current `rd_address` whenever credit is available, then increment the address. After address `frame_size-1` is issued, go to ST_DRAIN. The address never wraps.
  - ST_DRAIN: no reads. Return to ST_IDLE at the edge that pops the last word; `done` is high for that one cycle.
- Credit rule: issue a read only when `fifo_count + inflight + 1 <= fifo_depth`.
  - `inflight` is a `rd_latency`-deep valid shift register of issued reads.
  - This guarantees that no returning word is ever dropped and that the FIFO never overflows.
- Return path: when a read's valid emerges from the shift register, capture `rd_data` into the FIFO tail.
- Output stream handshake:
  - Head word drives `a_data`/`b_data`.
  - Per-word flags `a_taken` and `b_taken`. `a_valid` = FIFO non-empty and not `a_taken`; `b_valid` likewise.
  - A transfer on a stream occurs when its valid and ready are both high; that transfer sets the corresponding taken flag.
  - The head is popped when both streams have transferred. This may happen in the same cycle or in different cycles. Popping clears both flags.
  - Data and valid stay stable while not accepted.
- Simultaneous capture and pop in one cycle: count is unchanged and both operations occur.
- Reset mid-frame: in-flight reads are discarded, the FIFO empties, and the block returns to ST_IDLE. No `done` pulse is generated.

## Timing
- Accepted `start` at edge E. `rd_ena`=1 with address 0 in the cycle after E. Data is captured at edge E+1+`rd_latency`. `a_valid`/`b_valid` rise in that cycle.
- Start-to-first-valid latency: `rd_latency+1` clocks.
- With both readies held high, one word transfers per clock with no bubbles. A full frame completes in `frame_size+rd_latency+1` clocks after `start`.
- A stall on either stream blocks issue once credit runs out. Issue resumes the cycle after the pop that frees credit.
- `idle` rises and `done` pulses in the same cycle, directly after the final pop edge. A `start` asserted in that idle cycle is accepted.

## Test plan
- Use `width`=4, `height`=2 (`frame_size`=8) and `rd_latency`=2. The BRAM model returns `{a=13'h100+addr, b=8'hA0+addr}`. For the scenarios below, `start` with both readies high.
  - Back-to-back frame: `rd_ena` is high for 8 consecutive cycles. a/b sequences are 0x100..0x107 and 0xA0..0xA7. `done` pulses 11 clocks after `start`.
  - Bank select: `bram_index_in`=1 → `rd_bram_index`=1 for the whole frame.
- Hold `b_ready`=0 after the first word, with `a_ready`=1.
  - Stream a takes word 0x100 and `a_valid` drops.
  - `rd_ena` stops once `fifo_count+inflight`=4.
  - Releasing `b_ready` resumes in-order output with no loss or duplication.
- Random independent readies (≈50%) over 20 frames: every word appears exactly once per stream, in order. FIFO count never exceeds 4.
- `start` pulsed mid-frame: ignored; addresses continue without restart.
- Assert `reset` at word 3 while a read is in flight: outputs return to their reset values immediately, and no `done` pulse occurs. A fresh `start` then reads from address 0.
